// File: rtl/dcm_freq_governor_if.sv
// Host-command and DCM-programmer signal bundle for the frequency governor.
// The slave modport is the governor; the master modport is its environment.
interface dcm_freq_governor_if;
  // Host / command-decoder side
  logic       host_valid;
  logic [7:0] host_mult;
  logic       throttle;
  // DCM programmer side
  logic       prog_ready;
  logic       prog_done;
  logic       prog_start;
  logic [7:0] prog_mult;
  // Status
  logic [7:0] cur_mult;
  logic       busy;
  logic       timeout_err;

  modport master (
    output host_valid,
    output host_mult,
    output throttle,
    output prog_ready,
    output prog_done,
    input  prog_start,
    input  prog_mult,
    input  cur_mult,
    input  busy,
    input  timeout_err
  );

  modport slave (
    input  host_valid,
    input  host_mult,
    input  throttle,
    input  prog_ready,
    input  prog_done,
    output prog_start,
    output prog_mult,
    output cur_mult,
    output busy,
    output timeout_err
  );
endinterface

// File: rtl/dcm_freq_governor.sv
// DCM frequency governor: tracks a host-requested multiplier (or the throttle
// floor), ramps upward one step per reprogram, drops downward immediately,
// waits for the programmer to confirm each step and then lets the clock settle.
module dcm_freq_governor #(
  parameter int unsigned MIN_MULT       = 2,
  parameter int unsigned MAX_MULT       = 64,
  parameter int unsigned INIT_MULT      = 16,
  parameter int unsigned SETTLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic                clk,
  input logic                reset,
  dcm_freq_governor_if.slave bus
);

  localparam logic [7:0]  MinMult     = 8'(MIN_MULT);
  localparam logic [7:0]  MaxMult     = 8'(MAX_MULT);
  localparam logic [7:0]  InitMult    = 8'(INIT_MULT);
  // Counters are loaded/compared against count-1 so the dwell is exactly N cycles
  localparam logic [15:0] SettleLoad  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StSettle
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  host_target_q, host_target_d;
  logic [7:0]  cur_mult_q, cur_mult_d;
  logic [7:0]  prog_mult_q, prog_mult_d;
  logic        timeout_err_q, timeout_err_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [15:0] settle_cnt_q, settle_cnt_d;

  logic [7:0]  clamped_mult;
  logic [7:0]  eff_target;
  logic [7:0]  next_step;
  logic        need_change;

  // Clamp the incoming host request into the legal multiplier window
  always_comb begin
    clamped_mult = bus.host_mult;
    if (bus.host_mult < MinMult) begin
      clamped_mult = MinMult;
    end else if (bus.host_mult > MaxMult) begin
      clamped_mult = MaxMult;
    end
  end

  assign eff_target  = bus.throttle ? MinMult : host_target_q;
  assign need_change = (cur_mult_q != eff_target);

  // Next multiplier to program: unknown -> jump, upward -> +1, downward -> jump
  always_comb begin
    next_step = eff_target;
    if (cur_mult_q != 8'd0 && cur_mult_q < eff_target) begin
      next_step = cur_mult_q + 8'd1;
    end
  end

  // State and datapath registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      host_target_q <= InitMult;
      cur_mult_q    <= 8'd0;
      prog_mult_q   <= 8'd0;
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= 16'd0;
      settle_cnt_q  <= 16'd0;
    end else begin
      state_q       <= state_d;
      host_target_q <= host_target_d;
      cur_mult_q    <= cur_mult_d;
      prog_mult_q   <= prog_mult_d;
      timeout_err_q <= timeout_err_d;
      tmo_cnt_q     <= tmo_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d       = state_q;
    host_target_d = host_target_q;
    cur_mult_d    = cur_mult_q;
    prog_mult_d   = prog_mult_q;
    timeout_err_d = timeout_err_q;
    tmo_cnt_d     = tmo_cnt_q;
    settle_cnt_d  = settle_cnt_q;

    // Host requests are captured in every state; they only act at the next IDLE decision
    if (bus.host_valid) begin
      host_target_d = clamped_mult;
    end

    unique case (state_q)
      StIdle: begin
        if (need_change && bus.prog_ready) begin
          prog_mult_d = next_step;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        tmo_cnt_d = 16'd0;
        state_d   = StWaitDone;
      end
      StWaitDone: begin
        if (bus.prog_done) begin
          cur_mult_d   = prog_mult_q;
          settle_cnt_d = SettleLoad;
          state_d      = StSettle;
        end else if (tmo_cnt_q == TimeoutLast) begin
          // Give up on this step; cur_mult keeps the last confirmed value
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      StSettle: begin
        if (settle_cnt_q == 16'd0) begin
          state_d = StIdle;
        end else begin
          settle_cnt_d = settle_cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    bus.prog_start  = (state_q == StIssue);
    bus.busy        = (state_q != StIdle);
    bus.prog_mult   = prog_mult_q;
    bus.cur_mult    = cur_mult_q;
    bus.timeout_err = timeout_err_q;
  end

endmodule
